// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// SRAM-like data bus between the load/store unit and data memory: a
// single-outstanding request with an addr_ok / data_ok handshake.
//
// Signals:
//   data_req      unit -> mem  request valid, held until data_addr_ok
//   data_wr       unit -> mem  1 = write, 0 = read
//   data_size     unit -> mem  0 byte, 1 half, 2 word
//   data_addr     unit -> mem  full byte address
//   data_wdata    unit -> mem  store data replicated across byte lanes
//   data_wstrb    unit -> mem  byte strobes (all zero on reads)
//   data_addr_ok  mem -> unit  address accepted
//   data_data_ok  mem -> unit  read data valid / write complete
//   data_rdata    mem -> unit  read data
//
// Modports: master (load/store unit side), slave (memory side).
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store unit behind the M stage. Turns the M-stage address, store data
// and access type into one transaction on the data bus, formats store data
// and byte strobes, and sign/zero-extends load data into rdata_out. Holds
// the pipeline (mem_stall) while a transaction is in flight.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   mem_en        M-stage instruction accesses memory
//   mem_wr        1 = store, 0 = load
//   mem_type      00 byte, 01 half, 10/11 word
//   mem_unsigned  zero-extend loads (LBU/LHU)
//   addr          M-stage effective address
//   wdata         unaligned store value
//   flush         cancel the current M-stage instruction
//   hold          external M-stage stall; keeps the unit in DONE
//   rdata_out     registered, aligned and extended load result
//   mem_stall     pipeline stall request
//   adel / ades   load / store address error (combinational)
//   bus_err       1-cycle bus timeout pulse (timeout build only)
//   bus           data bus, master side of mem_access_unit_if
//
// Build option: define MEM_ACCESS_TIMEOUT_EN to add a TIMEOUT_CYCLES
// watchdog on the ADDR/DATA wait. Without it the unit waits indefinitely
// and neither bus_err nor TIMEOUT_CYCLES exists.
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 32
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [1:0]        mem_type,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              flush,
  input  logic              hold,
  output logic [31:0]       rdata_out,
  output logic              mem_stall,
  output logic              adel,
  output logic              ades,
`ifdef MEM_ACCESS_TIMEOUT_EN
  output logic              bus_err,
`endif
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT state;
  logic  cancelR;       // request was flushed while on the bus
  logic  loadUnsigned;  // captured mem_unsigned of the in-flight load

  // Bus size encoding; type 11 is treated as a word.
  function automatic logic [1:0] busSize(input logic [1:0] t);
    case (t)
      2'b00:   busSize = 2'd0;
      2'b01:   busSize = 2'd1;
      default: busSize = 2'd2;
    endcase
  endfunction

  // Replicate the store value across every lane it could land in.
  function automatic logic [31:0] storeData(input logic [1:0] t, input logic [31:0] wd);
    case (t)
      2'b00:   storeData = {4{wd[7:0]}};
      2'b01:   storeData = {2{wd[15:0]}};
      default: storeData = wd;
    endcase
  endfunction

  function automatic logic [3:0] storeStrb(input logic [1:0] t, input logic [1:0] off);
    case (t)
      2'b00:   storeStrb = 4'b0001 << off;
      2'b01:   storeStrb = off[1] ? 4'b1100 : 4'b0011;
      default: storeStrb = 4'b1111;
    endcase
  endfunction

  // Pick the addressed byte/half out of the bus word and extend it.
  function automatic logic [31:0] fmtLoad(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'd0:    fmtLoad = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    fmtLoad = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: fmtLoad = w;
    endcase
  endfunction

  logic misaligned;
  logic startReq;
  logic cancelNow;
  logic completing;

  assign misaligned = ((mem_type == 2'b01) & addr[0]) |
                      (mem_type[1] & (addr[1:0] != 2'b00));
  assign adel       = mem_en & ~mem_wr & misaligned;
  assign ades       = mem_en &  mem_wr & misaligned;
  assign startReq   = mem_en & ~misaligned & ~flush;
  // A flush seen at any point of the handshake cancels the write-back.
  assign cancelNow  = cancelR | flush;
  // addr_ok is only honoured in ADDR; in DATA only data_ok matters.
  assign completing = ((state == ADDR) & bus.data_addr_ok & bus.data_data_ok) |
                      ((state == DATA) & bus.data_data_ok);
  assign mem_stall  = ((state == IDLE) & startReq) | (state == ADDR) | (state == DATA);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] waitCnt;
  logic             timeoutHit;

  // TIMEOUT_CYCLES cycles spent in ADDR+DATA without completion.
  assign timeoutHit = (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: cleared when a request starts, counts while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt <= '0;
    end else if (state == IDLE && startReq) begin
      waitCnt <= '0;
    end else if (state == ADDR || state == DATA) begin
      waitCnt <= waitCnt + CNT_W'(1);
    end else begin
      waitCnt <= waitCnt;
    end
  end
`endif

  // Transaction FSM with registered bus fields and load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rdata_out      <= 32'd0;
      cancelR        <= 1'b0;
      loadUnsigned   <= 1'b0;
      bus.data_req   <= 1'b0;
      bus.data_wr    <= 1'b0;
      bus.data_size  <= 2'd0;
      bus.data_addr  <= '0;
      bus.data_wdata <= 32'd0;
      bus.data_wstrb <= 4'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      bus_err        <= 1'b0;
`endif
    end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (startReq) begin
            state          <= ADDR;
            cancelR        <= 1'b0;
            loadUnsigned   <= mem_unsigned;
            bus.data_req   <= 1'b1;
            bus.data_wr    <= mem_wr;
            bus.data_size  <= busSize(mem_type);
            bus.data_addr  <= addr;
            bus.data_wdata <= storeData(mem_type, wdata);
            bus.data_wstrb <= mem_wr ? storeStrb(mem_type, addr[1:0]) : 4'b0000;
          end else begin
            state <= IDLE;
          end
        end
        ADDR, DATA: begin
          if (completing) begin
            bus.data_req <= 1'b0;
            cancelR      <= 1'b0;
            if (cancelNow) begin
              // Flushed instruction: drain the bus but never write back.
              state <= IDLE;
            end else begin
              state <= DONE;
              // Stores complete without touching the last load result.
              if (!bus.data_wr) begin
                rdata_out <= fmtLoad(bus.data_rdata, bus.data_addr[1:0],
                                     bus.data_size, loadUnsigned);
              end else begin
                rdata_out <= rdata_out;
              end
            end
          end else if (state == ADDR && bus.data_addr_ok) begin
            bus.data_req <= 1'b0;
            state        <= DATA;
            cancelR      <= cancelNow;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (timeoutHit) begin
            // Abandon the request; a late data_ok lands outside ADDR/DATA.
            bus.data_req <= 1'b0;
            cancelR      <= 1'b0;
            state        <= DONE;
            rdata_out    <= 32'hDEAD_BEEF;
            bus_err      <= 1'b1;
          end
`endif
          else begin
            state   <= state;
            cancelR <= cancelNow;
          end
        end
        DONE: begin
          if (flush || !hold) begin
            state <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit. Inputs change 1 time unit after the
// rising edge; outputs are sampled there too (after combinational settle).
// Expected load results are queued when an access is issued and popped when
// the unit reaches DONE.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_wr;
  logic [1:0]  mem_type;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        hold;
  logic [31:0] rdata_out;
  logic        mem_stall;
  logic        adel;
  logic        ades;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [31:0] expQ[$];

  mem_access_unit_if #(.ADDR_W(32)) busIf ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_type     (mem_type),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .flush        (flush),
    .hold         (hold),
    .rdata_out    (rdata_out),
    .mem_stall    (mem_stall),
    .adel         (adel),
    .ades         (ades),
    .bus          (busIf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access starting in IDLE; the bench plays the memory.
  task automatic access(input logic wr, input logic [1:0] typ, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int aDly, input int dDly, input logic [31:0] rd,
                        input logic [31:0] expRd, input logic [31:0] expWd,
                        input logic [3:0] expStrb, input logic [1:0] expSize,
                        input int holdCyc);
    logic [31:0] exp;
    mem_en = 1'b1; mem_wr = wr; mem_type = typ; mem_unsigned = uns;
    addr = a; wdata = wd; flush = 1'b0; hold = 1'b0;
    #1;
    chk("idle_stall", mem_stall, 32'd1);
    chk("idle_noreq", busIf.data_req, 32'd0);
    expQ.push_back(expRd);
    tick();
    for (int i = 0; i <= aDly; i++) begin
      chk("addr_req", busIf.data_req, 32'd1);
      chk("addr_stall", mem_stall, 32'd1);
      chk("addr_wr", busIf.data_wr, 32'(wr));
      chk("addr_size", busIf.data_size, 32'(expSize));
      chk("addr_addr", busIf.data_addr, a);
      chk("addr_strb", busIf.data_wstrb, 32'(expStrb));
      if (wr) chk("addr_wdata", busIf.data_wdata, expWd);
      if (i == aDly) begin
        busIf.data_addr_ok = 1'b1;
        if (dDly == 0) begin
          busIf.data_data_ok = 1'b1;
          busIf.data_rdata   = rd;
        end
      end
      tick();
      busIf.data_addr_ok = 1'b0;
      busIf.data_data_ok = 1'b0;
    end
    for (int j = 1; j <= dDly; j++) begin
      chk("data_noreq", busIf.data_req, 32'd0);
      chk("data_stall", mem_stall, 32'd1);
      if (j == dDly) begin
        busIf.data_data_ok = 1'b1;
        busIf.data_rdata   = rd;
      end
      tick();
      busIf.data_data_ok = 1'b0;
    end
    exp = expQ.pop_front();
    chk("done_stall", mem_stall, 32'd0);
    chk("done_rdata", rdata_out, exp);
    if (holdCyc > 0) hold = 1'b1;
    for (int k = 0; k < holdCyc; k++) begin
      tick();
      chk("hold_rdata", rdata_out, exp);
      chk("hold_stall", mem_stall, 32'd0);
    end
    hold = 1'b0;
    mem_en = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; mem_type = 2'd0; mem_unsigned = 1'b0;
    addr = 32'd0; wdata = 32'd0; flush = 1'b0; hold = 1'b0;
    busIf.data_addr_ok = 1'b0; busIf.data_data_ok = 1'b0; busIf.data_rdata = 32'd0;
    tick();
    tick();
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_req", busIf.data_req, 32'd0);
    chk("rst_addr", busIf.data_addr, 32'd0);
    chk("rst_strb", busIf.data_wstrb, 32'd0);
    chk("rst_stall", mem_stall, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Loads and stores across sizes, offsets and handshake delays
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, 32'h12345678,
           32'h12345678, 32'h0, 4'b0000, 2'd2, 0);
    access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1, 1, 32'h80FF0000,
           32'hFFFFFF80, 32'h0, 4'b0000, 2'd0, 0);
    access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 2, 32'h80FF0000,
           32'h00000080, 32'h0, 4'b0000, 2'd0, 0);
    access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 3, 1, 32'h0,
           32'h00000080, 32'hABCDABCD, 4'b1100, 2'd1, 0);
    access(1'b1, 2'b00, 1'b0, 32'h001, 32'h11223344, 0, 1, 32'h0,
           32'h00000080, 32'h44444444, 4'b0010, 2'd0, 0);
    access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 0, 32'h80011234,
           32'hFFFF8001, 32'h0, 4'b0000, 2'd1, 0);
    access(1'b0, 2'b01, 1'b1, 32'h000, 32'h0, 2, 0, 32'h1234F00D,
           32'h0000F00D, 32'h0, 4'b0000, 2'd1, 0);
    access(1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEBABE, 1, 0, 32'h0,
           32'h0000F00D, 32'hCAFEBABE, 4'b1111, 2'd2, 0);
    access(1'b0, 2'b11, 1'b0, 32'h108, 32'h0, 0, 1, 32'hA5A5A5A5,
           32'hA5A5A5A5, 32'h0, 4'b0000, 2'd2, 0);

    // Address errors: no request, no stall
    mem_en = 1'b1; mem_wr = 1'b0; mem_type = 2'b10; addr = 32'h101;
    #1;
    chk("lw_adel", adel, 32'd1);
    chk("lw_ades", ades, 32'd0);
    chk("lw_err_stall", mem_stall, 32'd0);
    tick();
    chk("lw_err_noreq", busIf.data_req, 32'd0);
    mem_wr = 1'b1; addr = 32'h102;
    #1;
    chk("sw_ades", ades, 32'd1);
    chk("sw_adel", adel, 32'd0);
    chk("sw_err_stall", mem_stall, 32'd0);
    tick();
    chk("sw_err_noreq", busIf.data_req, 32'd0);
    mem_type = 2'b01; addr = 32'h201;
    #1;
    chk("sh_ades", ades, 32'd1);
    mem_wr = 1'b0; addr = 32'h202;
    #1;
    chk("lh_ok_adel", adel, 32'd0);
    chk("lh_ok_stall", mem_stall, 32'd1);
    mem_en = 1'b0;
    tick();

    // Flush in IDLE: nothing issued
    mem_en = 1'b1; mem_wr = 1'b0; mem_type = 2'b10; addr = 32'h700; flush = 1'b1;
    #1;
    chk("flush_idle_stall", mem_stall, 32'd0);
    tick();
    chk("flush_idle_noreq", busIf.data_req, 32'd0);
    mem_en = 1'b0; flush = 1'b0;
    tick();

    // Flush in DATA: handshake completes, result discarded, back to IDLE
    mem_en = 1'b1; addr = 32'h300;
    tick();
    chk("fl_addr_req", busIf.data_req, 32'd1);
    busIf.data_addr_ok = 1'b1;
    tick();
    busIf.data_addr_ok = 1'b0;
    flush = 1'b1; mem_en = 1'b0;
    #1;
    chk("fl_data_stall", mem_stall, 32'd1);
    tick();
    flush = 1'b0;
    chk("fl_drain_stall", mem_stall, 32'd1);
    chk("fl_drain_noreq", busIf.data_req, 32'd0);
    busIf.data_data_ok = 1'b1; busIf.data_rdata = 32'hFFFFFFFF;
    tick();
    busIf.data_data_ok = 1'b0;
    chk("fl_rdata_kept", rdata_out, 32'hA5A5A5A5);
    // A new request must stall immediately, proving the unit is in IDLE
    access(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 0, 0, 32'h600DCAFE,
           32'h600DCAFE, 32'h0, 4'b0000, 2'd2, 0);

    // Asynchronous reset while in DATA
    mem_en = 1'b1; mem_wr = 1'b0; mem_type = 2'b10; addr = 32'h500;
    tick();
    busIf.data_addr_ok = 1'b1;
    tick();
    busIf.data_addr_ok = 1'b0;
    mem_en = 1'b0;
    chk("rstd_stall_pre", mem_stall, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstd_req", busIf.data_req, 32'd0);
    chk("rstd_rdata", rdata_out, 32'd0);
    chk("rstd_stall", mem_stall, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rstd_idle_req", busIf.data_req, 32'd0);

    // hold in DONE keeps the result stable
    access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0, 0, 32'h0BADF00D,
           32'h0BADF00D, 32'h0, 4'b0000, 2'd2, 5);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit directly downstream of the datapath's memory stage. It takes the M-stage address (ALU result), store data and access type, and drives a single-outstanding SRAM-like data bus with an addr_ok/data_ok handshake. It produces byte strobes, replicated store data and sign/zero-extended load data. It raises address-error flags and asserts a stall to the hazard unit while a transaction is in flight.

Parameters:
TIMEOUT_CYCLES, 256, max cycles in ADDR+DATA before bus error (used only with optional feature)
ADDR_W, 32, bus address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
mem_en  in  1  M-stage instruction accesses memory
mem_wr  in  1  1=store, 0=load
mem_type  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned  in  1  zero-extend loads (LBU/LHU)
addr  in  32  M-stage effective address
wdata  in  32  unaligned store value (rt)
flush  in  1  cancel current M-stage instruction
hold  in  1  external M-stage stall from the hazard unit
rdata_out  out  32  aligned, extended load result
mem_stall  out  1  pipeline stall request
adel  out  1  load address error
ades  out  1  store address error
data_req  out  1  bus request
data_wr  out  1  bus write
data_size  out  2  0 byte, 1 half, 2 word
data_addr  out  32  bus address, full byte address
data_wdata  out  32  replicated store data
data_wstrb  out  4  byte strobes
data_addr_ok  in  1  address accepted
data_data_ok  in  1  read data valid / write complete
data_rdata  in  32  read data

Behaviour:
- Reset (rst=0, async): state=IDLE; rdata_out=0; data_req=0; data_wr/size/addr/wdata/wstrb registers=0; cancel flag=0.
- Address error (combinational): misaligned half = addr[0]=1; misaligned word = addr[1:0]!=0. Raise adel when mem_en&~mem_wr, ades when mem_en&mem_wr. On error: no request, no stall.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE → ADDR: mem_en & ~err & ~flush. Register all request fields on this edge.
  - ADDR: data_req=1, fields held stable. On addr_ok → DATA. If addr_ok & data_ok in the same cycle → DONE directly.
  - DATA → DONE: on data_ok. Capture data_rdata on that edge.
  - DONE → IDLE: when ~hold; stays in DONE while hold=1, with rdata_out stable.
- mem_stall = (IDLE & mem_en & ~err & ~flush) | ADDR | DATA. Deasserted in DONE.
- Minimum latency: request seen in IDLE, 1 cycle in ADDR with addr_ok&data_ok, DONE on cycle 3, stall low on cycle 3.
- Store formatting:
  - SB: wdata={4{wdata[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{wdata[15:0]}}, wstrb=addr[1]?1100:0011.
  - SW: wdata unchanged, wstrb=1111.
  - Loads: wstrb=0000.
- Load formatting: select byte/half from captured word using addr[1:0], then sign-extend, or zero-extend if mem_unsigned. rdata_out is registered and valid in DONE; it holds its value until the next capture.
- Flush:
  - In IDLE or DONE: immediately → IDLE, no request.
  - In ADDR or DATA: the request is never dropped. Set the cancel flag, complete the handshake, skip the rdata_out update, go to IDLE (not DONE). Stall stays asserted until the bus drains.
- Only one transaction outstanding; addr_ok is never accepted while in DATA.

Optional Feature:
MEM_ACCESS_TIMEOUT_EN
- Defined:
  - Adds a cycle counter, cleared on IDLE→ADDR, incremented in ADDR/DATA.
  - Reaching TIMEOUT_CYCLES forces → DONE, pulses a 1-cycle output bus_err, and loads rdata_out=32'hDEADBEEF.
  - Late data_ok for the abandoned request is ignored.
- Not defined: no counter and no bus_err port; the FSM waits indefinitely.

Test Plan:
- LW addr=0x100, addr_ok&data_ok same cycle, rdata=0x12345678 → stall high cycles 1-2, rdata_out=0x12345678 in cycle 3, data_size=2, wstrb=0000.
- LB addr=0x103, rdata=0x80FF0000: signed → rdata_out=0xFFFFFF80; LBU → 0x00000080.
- SH addr=0x202, wdata=0x0000ABCD, addr_ok delayed 3 cycles → data_req held 4 cycles, data_wdata=0xABCDABCD, wstrb=1100, fields stable throughout.
- LW addr=0x101 → adel=1, data_req never asserted, mem_stall=0; SW addr=0x102 → ades=1.
- Flush asserted in DATA, data_ok 2 cycles later → handshake completes, state returns to IDLE, rdata_out unchanged from prior value.
- rst pulled low in DATA → data_req=0, state=IDLE, rdata_out=0 immediately; hold=1 in DONE keeps rdata_out stable 5 cycles.
